// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch-predictor update sequencer.
package bpu_pkg;

    localparam int BPU_XLEN = 32;
    localparam logic [BPU_XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BTB_WR  = 2'd1,
        ST_PHT_UPD = 2'd2
    } bpu_state_e;

    typedef struct packed {
        logic [BPU_XLEN-1:0] pc;
        logic [BPU_XLEN-1:0] target;
        logic                taken;
        logic                need_btb;
    } upd_entry_t;

    // Fetch restart address after a mispredict; the fall-through add wraps modulo 2^XLEN.
    function automatic logic [BPU_XLEN-1:0] restart_pc(
        input logic                taken,
        input logic [BPU_XLEN-1:0] target,
        input logic [BPU_XLEN-1:0] pc
    );
        logic [BPU_XLEN-1:0] addr;
        if (taken) begin
            addr = target;
        end else begin
            addr = pc + PC_INC;
        end
        return addr;
    endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Update queue: synchronous FIFO whose pointers carry an extra wrap bit.
module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  upd_entry_t              push_data_i,
    input  logic                    pop_i,
    output upd_entry_t              head_o,
    output upd_entry_t              next_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);

    upd_entry_t     mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic [AW-1:0]  rd_idx_nxt_s;
    logic           do_push_s;
    logic           do_pop_s;

    assign count_o      = wr_ptr_q - rd_ptr_q;
    assign full_o       = (count_o == (AW+1)'(DEPTH));
    assign empty_o      = (wr_ptr_q == rd_ptr_q);
    assign do_push_s    = push_i & ~full_o;
    assign do_pop_s     = pop_i & ~empty_o;
    assign rd_idx_nxt_s = rd_ptr_q[AW-1:0] + AW'(1'b1);
    // next_o lets the sequencer chain straight into the following entry on a pop.
    assign head_o       = mem_q[rd_ptr_q[AW-1:0]];
    assign next_o       = mem_q[rd_idx_nxt_s];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1'b1);
            end
        end
    end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Branch update sequencer: mispredict flush/redirect plus serialised BTB/PHT update strobes.
// Optional statistics counters are built when BPU_STATS_EN is defined.
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int XLEN  = BPU_XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic            ex_pred_hit,
    input  logic [XLEN-1:0] ex_pred_addr,
    input  logic            bpu_hold,
    output logic [XLEN-1:0] ADDR_EX,
    output logic [XLEN-1:0] Pred_EX,
    output logic            state_write,
    output logic            state_change,
    output logic            branch,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            q_full,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count,
    output logic [15:0]     drop_count
);

    localparam int AW = $clog2(DEPTH);

    logic            res_s;
    logic            mispred_s;
    logic            pop_s;
    logic            more_s;
    logic            full_s;
    logic            empty_s;
    logic [AW:0]     count_s;
    upd_entry_t      push_entry_s;
    upd_entry_t      head_s;
    upd_entry_t      next_s;
    upd_entry_t      sel_s;
    bpu_state_e      state_q;
    bpu_state_e      state_d;
    logic            flush_q;
    logic [XLEN-1:0] redirect_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] pred_q;
    logic            branch_q;

    assign res_s     = ex_valid & ex_is_branch;
    assign mispred_s = res_s & ((ex_taken != ex_pred_taken) |
                                (ex_taken & (ex_pred_addr != ex_target)));

    assign push_entry_s.pc       = ex_pc;
    assign push_entry_s.target   = ex_target;
    assign push_entry_s.taken    = ex_taken;
    assign push_entry_s.need_btb = ex_taken & (~ex_pred_hit | (ex_pred_addr != ex_target));

    bpu_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (res_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .next_o      (next_s),
        .count_o     (count_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    assign q_full = full_s;
    assign more_s = (count_s > (AW+1)'(1'b1));

    // Mispredict flush pulse and restart address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q <= mispred_s;
            if (mispred_s) begin
                redirect_q <= restart_pc(ex_taken, ex_target, ex_pc);
            end else begin
                redirect_q <= redirect_q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; PHT_UPD chains into the following entry without visiting IDLE.
    always_comb begin
        state_d = state_q;
        if (bpu_hold) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        state_d = head_s.need_btb ? ST_BTB_WR : ST_PHT_UPD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BTB_WR: state_d = ST_PHT_UPD;
                ST_PHT_UPD: begin
                    if (more_s) begin
                        state_d = next_s.need_btb ? ST_BTB_WR : ST_PHT_UPD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: strobes are suppressed while the predictor is held.
    always_comb begin
        state_write  = 1'b0;
        state_change = 1'b0;
        pop_s        = 1'b0;
        if (bpu_hold) begin
            state_write  = 1'b0;
            state_change = 1'b0;
        end else begin
            case (state_q)
                ST_BTB_WR:  state_write = 1'b1;
                ST_PHT_UPD: begin
                    state_change = 1'b1;
                    pop_s        = 1'b1;
                end
                default: begin
                    state_write  = 1'b0;
                    state_change = 1'b0;
                end
            endcase
        end
    end

    assign sel_s = pop_s ? next_s : head_s;

    // Update payload registers, loaded for the entry the FSM is about to serve.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            pred_q   <= '0;
            branch_q <= 1'b0;
        end else if (state_d != ST_IDLE) begin
            addr_q   <= sel_s.pc;
            pred_q   <= sel_s.target;
            branch_q <= sel_s.taken;
        end else begin
            addr_q   <= addr_q;
            pred_q   <= pred_q;
            branch_q <= branch_q;
        end
    end

    assign ADDR_EX     = addr_q;
    assign Pred_EX     = pred_q;
    assign branch      = branch_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

`ifdef BPU_STATS_EN
    logic        drop_s;
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;
    logic [15:0] drop_cnt_q;

    assign drop_s = res_s & full_s;

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q   <= 32'd0;
            mis_cnt_q  <= 32'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            if (res_s && !(&br_cnt_q)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispred_s && !(&mis_cnt_q)) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
            if (drop_s && !(&drop_cnt_q)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
    assign drop_count    = drop_cnt_q;
`else
    assign br_count      = 32'd0;
    assign mispred_count = 32'd0;
    assign drop_count    = 16'd0;
`endif

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Self-checking bench for bpu_update_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model (ordered list of expected update operations).
module tb_bpu_update_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken, ex_pred_hit, bpu_hold;
    logic [31:0] ex_pc, ex_target, ex_pred_addr;
    logic [31:0] ADDR_EX, Pred_EX, redirect_pc;
    logic        state_write, state_change, branch, flush, q_full;
    logic [31:0] br_count, mispred_count;
    logic [15:0] drop_count;

    bpu_update_ctrl #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_pred_hit(ex_pred_hit), .ex_pred_addr(ex_pred_addr),
        .bpu_hold(bpu_hold), .ADDR_EX(ADDR_EX), .Pred_EX(Pred_EX),
        .state_write(state_write), .state_change(state_change), .branch(branch),
        .flush(flush), .redirect_pc(redirect_pc), .q_full(q_full),
        .br_count(br_count), .mispred_count(mispred_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } op_t;

    op_t exp_q[$];
    int  mdl_cnt;
    int  m_br, m_mis, m_drop;
    int  n_checks, n_errors;
    bit  sw_seen, sc_seen;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_cnt = 0;
        m_br = 0;
        m_mis = 0;
        m_drop = 0;
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic v, input logic br, input logic tk, input logic ptk,
                         input logic phit, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] paddr, input logic hold);
        op_t         op;
        bit          res, mis, push, need;
        logic [31:0] rdir;
        ex_valid = v; ex_is_branch = br; ex_taken = tk; ex_pred_taken = ptk;
        ex_pred_hit = phit; ex_pc = pc; ex_target = tgt; ex_pred_addr = paddr;
        bpu_hold = hold;
        #1;
        sw_seen = state_write;
        sc_seen = state_change;
        check_eq("q_full", q_full, mdl_cnt == DEPTH);
        if (hold) begin
            check_eq("hold_sw", state_write, 0);
            check_eq("hold_sc", state_change, 0);
        end
        if (state_write && state_change) begin
            check_eq("both_strobes", 1, 0);
        end else if (state_write || state_change) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_op", 1, 0);
            end else begin
                op = exp_q.pop_front();
                check_eq("op_kind_wr", state_write, op.is_wr);
                check_eq("op_pc", ADDR_EX, op.pc);
                if (op.is_wr) check_eq("op_tgt", Pred_EX, op.tgt);
                else check_eq("op_branch", branch, op.taken);
            end
        end
        res  = v & br;
        mis  = res & ((tk != ptk) | (tk & (paddr != tgt)));
        need = tk & (!phit | (paddr != tgt));
        rdir = tk ? tgt : pc + 32'd4;
        push = res && (mdl_cnt != DEPTH);
        @(posedge clk);
        #1;
        check_eq("flush", flush, mis);
        if (mis) check_eq("redirect", redirect_pc, rdir);
        mdl_cnt = mdl_cnt + (push ? 1 : 0) - (sc_seen ? 1 : 0);
        if (push) begin
            if (need) exp_q.push_back('{1'b1, pc, tgt, tk});
            exp_q.push_back('{1'b0, pc, tgt, tk});
        end
        if (res) m_br++;
        if (mis) m_mis++;
        if (res && !push) m_drop++;
`ifdef BPU_STATS_EN
        check_eq("br_count", br_count, m_br);
        check_eq("mispred_count", mispred_count, m_mis);
        check_eq("drop_count", {16'd0, drop_count}, m_drop);
`else
        check_eq("br_count", br_count, 32'd0);
        check_eq("mispred_count", mispred_count, 32'd0);
        check_eq("drop_count", {16'd0, drop_count}, 32'd0);
`endif
    endtask

    task automatic idle(input logic hold);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, hold);
    endtask

    task automatic drain(input int budget, output int n_upd);
        n_upd = 0;
        for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
            idle(1'b0);
            if (sc_seen) n_upd++;
        end
        check_eq("drain_done", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_flush"}, flush, 0);
        check_eq({tag, "_redir"}, redirect_pc, 0);
        check_eq({tag, "_addr"}, ADDR_EX, 0);
        check_eq({tag, "_pred"}, Pred_EX, 0);
        check_eq({tag, "_sw"}, state_write, 0);
        check_eq({tag, "_sc"}, state_change, 0);
        check_eq({tag, "_br"}, branch, 0);
        check_eq({tag, "_qfull"}, q_full, 0);
        check_eq({tag, "_cnt"}, br_count | mispred_count | {16'd0, drop_count}, 0);
    endtask

    initial begin
        int n;
        logic [31:0] pc, tgt, paddr;
        logic tk, ptk, phit, hold;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst = 1'b0;
        ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_pred_taken = 0; ex_pred_hit = 0;
        ex_pc = 0; ex_target = 0; ex_pred_addr = 0; bpu_hold = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Taken, predicted not-taken, BTB miss
        cycle(1, 1, 1, 0, 0, 32'hfe941ee3, 32'h00140413, 32'h0, 0);
        check_eq("t1_flush", flush, 1);
        check_eq("t1_redir", redirect_pc, 32'h00140413);
        idle(0);
        check_eq("t1_pulse", flush, 0);
        check_eq("t1_sw_early", sw_seen, 0);
        idle(0);
        check_eq("t1_sw", sw_seen, 1);
        idle(0);
        check_eq("t1_sc", sc_seen, 1);
        check_eq("t1_branch", branch, 1);
        idle(0);

        // Not taken, predicted taken
        cycle(1, 1, 0, 1, 1, 32'h00090463, 32'h00090800, 32'h00090800, 0);
        check_eq("t2_redir", redirect_pc, 32'h00090467);
        idle(0);
        check_eq("t2_sc_early", sc_seen, 0);
        idle(0);
        check_eq("t2_sc", sc_seen, 1);
        check_eq("t2_sw", sw_seen, 0);
        check_eq("t2_branch", branch, 0);
        idle(0);

        // Correct prediction: taken, hit, matching address
        cycle(1, 1, 1, 1, 1, 32'h00001000, 32'h00002000, 32'h00002000, 0);
        check_eq("t3_noflush", flush, 0);
        idle(0);
        idle(0);
        check_eq("t3_sc", sc_seen, 1);
        check_eq("t3_sw", sw_seen, 0);
        idle(0);

        // Five resolves while held: fifth is dropped, four drain in order
        for (int i = 0; i < 5; i++) begin
            tk = i[0];
            cycle(1, 1, tk, tk, 1, 32'h100 + 32'(i) * 32'h10, 32'h800, 32'h800, 1);
            if (i == 3) check_eq("t4_full", q_full, 1);
        end
`ifdef BPU_STATS_EN
        check_eq("t4_drop", {16'd0, drop_count}, 32'd1);
`endif
        drain(20, n);
        check_eq("t4_drained", n, 4);

        // Fall-through wraps at the top of the address space
        cycle(1, 1, 0, 1, 1, 32'hfffffffc, 32'h00000040, 32'h00000040, 0);
        check_eq("t5_wrap", redirect_pc, 32'h00000000);
        drain(10, n);

        // Reset during BTB_WR with three entries queued
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 0, 0, 32'h4000 + 32'(i) * 32'h4, 32'h8000, 32'h0, 1);
        end
        idle(0);
        bpu_hold = 0;
        #1;
        check_eq("t6_in_btbwr", state_write, 1);
        rst = 1'b0;
        #1;
        check_eq("t6_sw_async", state_write, 0);
        check_eq("t6_sc_async", state_change, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6");
        for (int i = 0; i < 4; i++) idle(0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tgt   = $urandom;
            pc    = $urandom;
            tk    = 1'($urandom_range(0, 1));
            ptk   = 1'($urandom_range(0, 1));
            phit  = 1'($urandom_range(0, 1));
            paddr = ($urandom_range(0, 2) != 0) ? tgt : $urandom;
            hold  = ($urandom_range(0, 4) == 0);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), tk, ptk, phit,
                  pc, tgt, paddr, hold);
        end
        drain(200, n);
        check_eq("final_cnt", mdl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
